rr_mux_arbiter: RTL

RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

---
 rtl/rr_mux_arbiter_pkg.sv | 13 +
 rtl/rr_mux_arbiter_pick.sv | 40 ++++
 rtl/rr_mux_arbiter.sv | 82 ++++++++
 3 files changed

// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and defaults for the round-robin output-mux arbiter.
// The two-state enum tracks whether the single output register holds a word.
package rr_mux_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int DEFAULT_N_REQ = 4;
    localparam int DEFAULT_W     = 8;

endpackage

// File: rtl/rr_mux_arbiter_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
// Produces a one-hot grant, its index and a flag saying anyone was found.
module rr_pick #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW:0]   sum;
    logic [IW-1:0] pos;

    // Scan from the farthest offset down so the nearest valid requester wins last.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        sum   = '0;
        pos   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (IW + 1)'(k);
            if (sum >= (IW + 1)'(N)) begin
                sum = sum - (IW + 1)'(N);
            end
            pos = sum[IW-1:0];
            if (req[pos]) begin
                idx = pos;
                any = 1'b1;
            end
        end
        if (any) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// N_REQ requesters share one registered W-bit output channel under round-robin.
// A word may be drained and a new one loaded in the same cycle for full throughput.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter  int N_REQ = DEFAULT_N_REQ,
    parameter  int W     = DEFAULT_W,
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ-1:0][W-1:0]    req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [W-1:0]               out_data,
    output logic [IW-1:0]              out_id
);

    state_t          state;
    logic [IW-1:0]   rr_ptr;
    logic [N_REQ-1:0] grant;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic            capacity;
    logic            accept;
    logic [W-1:0]    sel_data;

    rr_pick #(.N(N_REQ)) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Reset also gates the accept strobe so nothing is offered while it is held.
    assign capacity  = (state == IDLE) || out_ready;
    assign accept    = pick_any && capacity && !rst;
    assign req_ready = accept ? grant : '0;
    assign sel_data  = req_data[pick_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        out_data  <= sel_data;
                        out_id    <= pick_idx;
                        out_valid <= 1'b1;
                        rr_ptr    <= (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (accept) begin
                        out_data  <= sel_data;
                        out_id    <= pick_idx;
                        out_valid <= 1'b1;
                        rr_ptr    <= (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
                        state     <= BUSY;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
